// File: rtl/rom_load_ctrl.sv
// HPS ROM download sequencer: decodes ioctl bytes into CPU/sound/gfx regions,
// buffers them in a 2-entry FIFO and feeds a req/ack memory write port.
module rom_load_ctrl #(
  parameter int unsigned R0_SIZE = 'h10000,
  parameter int unsigned R1_SIZE = 'h01000,
  parameter int unsigned R2_SIZE = 'h10000,
  parameter int unsigned AW      = 17
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          wr_req,
  output logic [1:0]    wr_region,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic          wr_ack,
  output logic          rom_init,
  output logic          load_done,
  output logic          load_err,
  output logic [24:0]   byte_count,
  output logic [7:0]    dip_sw,
  output logic [7:0]    mod
);
  localparam logic [24:0] BASE1 = 25'(R0_SIZE);
  localparam logic [24:0] BASE2 = 25'(R0_SIZE + R1_SIZE);
  localparam logic [24:0] TOTAL = 25'(R0_SIZE + R1_SIZE + R2_SIZE);

  typedef struct packed {
    logic [1:0]    region;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ent_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  ent_t        fifo_q [2];
  ent_t        push_ent, head;
  logic        rptr, wptr;
  logic [1:0]  cnt, cnt_nxt;
  logic [24:0] off;
  logic        in_range, ld_wr, push, pop, issue, drop_full, wr_req_nxt, holdoff;

  assign head = fifo_q[rptr];

  always_comb begin
    off      = '0;
    in_range = 1'b1;
    push_ent = '0;
    if (ioctl_addr < BASE1) begin
      push_ent.region = 2'd0;
      off             = ioctl_addr;
    end else if (ioctl_addr < BASE2) begin
      push_ent.region = 2'd1;
      off             = ioctl_addr - BASE1;
    end else if (ioctl_addr < TOTAL) begin
      push_ent.region = 2'd2;
      off             = ioctl_addr - BASE2;
    end else begin
      in_range = 1'b0;
    end
    push_ent.addr = off[AW-1:0];
    push_ent.data = ioctl_dout;
  end

  assign ld_wr      = (state == LOAD) && ioctl_wr && (ioctl_index == 8'd0);
  assign push       = ld_wr && in_range && (cnt != 2'd2);
  // a strobe against a full FIFO means the HPS ignored ioctl_wait
  assign drop_full  = ld_wr && in_range && (cnt == 2'd2);
  assign pop        = wr_req && wr_ack;
  assign issue      = (cnt != 2'd0) && !wr_req;
  assign cnt_nxt    = cnt + {1'b0, push} - {1'b0, pop};
  assign wr_req_nxt = issue || (wr_req && !wr_ack);
  assign holdoff    = ((state == DRAIN) || (state == DONE)) && ioctl_download && (ioctl_index == 8'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ioctl_download && (ioctl_index == 8'd0)) state_nxt = LOAD;
      LOAD:    if (!ioctl_download) state_nxt = DRAIN;
      // finish on the ack edge itself so load_done follows the last ack directly
      DRAIN:   if ((cnt_nxt == 2'd0) && !wr_req_nxt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rptr       <= 1'b0;
      wptr       <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      ioctl_wait <= 1'b0;
      wr_req     <= 1'b0;
      wr_region  <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rom_init   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= '0;
      dip_sw     <= '0;
      mod        <= 8'hFF;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rom_init   <= (state_nxt == LOAD) || (state_nxt == DRAIN);
      load_done  <= (state_nxt == DONE);
      ioctl_wait <= (cnt_nxt == 2'd2) || holdoff;
      wr_req     <= wr_req_nxt;
      if (push) begin
        fifo_q[wptr] <= push_ent;
        wptr         <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (issue) {wr_region, wr_addr, wr_data} <= head;
      if ((state == IDLE) && (state_nxt == LOAD)) begin
        byte_count <= '0;
        load_err   <= 1'b0;
      end else begin
        if (ld_wr) byte_count <= byte_count + 25'd1;
        if ((ld_wr && !in_range) || drop_full) load_err <= 1'b1;
      end
      if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr == 25'd0)) dip_sw <= ioctl_dout;
      if (ioctl_wr && (ioctl_index == 8'd1)) mod <= ioctl_dout;
    end
  end
endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: random HPS stream and ack latency, checked against
// an address-rule model and an expected write-order queue.
module tb_rom_load_ctrl;
  localparam int R0  = 'h400;
  localparam int R1  = 'h100;
  localparam int R2  = 'h400;
  localparam int TOT = R0 + R1 + R2;

  logic        clk_sys, reset_n, ioctl_download, ioctl_wr, ioctl_wait;
  logic [7:0]  ioctl_index, ioctl_dout, wr_data, dip_sw, mod;
  logic [24:0] ioctl_addr, byte_count;
  logic        wr_req, wr_ack, rom_init, load_done, load_err;
  logic [1:0]  wr_region;
  logic [16:0] wr_addr;

  rom_load_ctrl #(.R0_SIZE(R0), .R1_SIZE(R1), .R2_SIZE(R2), .AW(17)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .wr_req(wr_req),
    .wr_region(wr_region), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rom_init(rom_init), .load_done(load_done), .load_err(load_err),
    .byte_count(byte_count), .dip_sw(dip_sw), .mod(mod)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int vectors = 0, errors = 0;
  int ack_dly = 1;
  int unstable = 0, done_cnt = 0, req_rise = 0;
  logic [26:0] got_q[$], exp_q[$];

  // memory port: accepts one request, acks ack_dly cycles after it appears
  initial begin : responder
    logic [26:0] cur;
    bit busy;
    int wc;
    busy = 0; wc = 0; cur = '0;
    wr_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      wr_ack = 1'b0;
      if (wr_req && reset_n) begin
        if (!busy) begin
          busy = 1; cur = {wr_region, wr_addr, wr_data}; wc = ack_dly;
        end else if ({wr_region, wr_addr, wr_data} !== cur) unstable++;
        if (wc == 0) begin
          wr_ack = 1'b1; got_q.push_back(cur); busy = 0;
        end else wc--;
      end else busy = 0;
    end
  end

  initial begin : monitor
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (load_done) done_cnt++;
      if (wr_req && !req_prev) req_rise++;
      req_prev = wr_req;
    end
  end

  // {valid, region, offset, data} from the region layout
  function automatic logic [27:0] model(input int a, input logic [7:0] d);
    if (a < R0)           return {1'b1, 2'd0, 17'(a), d};
    else if (a < R0 + R1) return {1'b1, 2'd1, 17'(a - R0), d};
    else if (a < TOT)     return {1'b1, 2'd2, 17'(a - R0 - R1), d};
    return '0;
  endfunction

  function automatic int first_diff(input int gb, input int eb, input int n);
    for (int i = 0; i < n; i++)
      if (gb + i >= got_q.size() || got_q[gb + i] !== exp_q[eb + i]) return i;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] idx, input int a, input logic [7:0] d, input bit honour);
    int t = 0;
    while (honour && ioctl_wait && t < 200) begin @(posedge clk_sys); #1; t++; end
    if (t >= 200) begin
      vectors++; errors++;
      $display("FAIL wait_timeout ioctl_wait=%0b required 0", ioctl_wait);
    end
    ioctl_index = idx; ioctl_addr = 25'(a); ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic hps_byte(input int a, input logic [7:0] d);
    logic [27:0] m;
    send_byte(8'd0, a, d, 1'b1);
    m = model(a, d);
    if (m[27]) exp_q.push_back(m[26:0]);
  endtask

  task automatic start_load();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (2) begin @(posedge clk_sys); #1; end
  endtask

  task automatic end_load(output bit found);
    int t = 0;
    ioctl_download = 1'b0;
    found = 0;
    while (!found && t < 500) begin
      @(posedge clk_sys); #1; t++;
      if (load_done) found = 1;
    end
    repeat (3) begin @(posedge clk_sys); #1; end
  endtask

  task automatic test_reset();
    logic [64:0] obs;
    #23;
    obs = {ioctl_wait, wr_req, wr_region, wr_addr, wr_data, rom_init, load_done, load_err, byte_count, dip_sw};
    vectors++; if (obs !== 65'd0) begin errors++; $display("FAIL reset_outputs got %h required 0", obs); end
    vectors++; if (mod !== 8'hFF) begin errors++; $display("FAIL reset_mod got %h required ff", mod); end
    @(posedge clk_sys); #1; reset_n = 1'b1;
    repeat (2) begin @(posedge clk_sys); #1; end
  endtask

  task automatic test_seq_load();
    int gb, eb, d0, fd, n;
    bit found;
    ack_dly = 1;
    gb = got_q.size(); eb = exp_q.size(); d0 = done_cnt;
    start_load();
    vectors++; if (rom_init !== 1'b1) begin errors++; $display("FAIL seq_rom_init got %b required 1", rom_init); end
    for (int a = 0; a < TOT; a++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk_sys); #1; end
      hps_byte(a, 8'(a));
    end
    end_load(found);
    n = exp_q.size() - eb;
    vectors++; if (found !== 1'b1) begin errors++; $display("FAIL seq_done no load_done, required pulse"); end
    vectors++; if (got_q.size() - gb !== n) begin errors++; $display("FAIL seq_count got %0d required %0d", got_q.size() - gb, n); end
    fd = first_diff(gb, eb, n);
    vectors++; if (fd !== -1) begin errors++; $display("FAIL seq_order write %0d got %h required %h", fd, got_q[gb + fd], exp_q[eb + fd]); end
    vectors++; if (got_q[gb + R0] !== {2'd1, 17'd0, 8'(R0)}) begin errors++; $display("FAIL seq_r1_first got %h required r1 off 0", got_q[gb + R0]); end
    vectors++; if (got_q[gb + R0 + R1] !== {2'd2, 17'd0, 8'(R0 + R1)}) begin errors++; $display("FAIL seq_r2_first got %h required r2 off 0", got_q[gb + R0 + R1]); end
    vectors++; if (got_q[gb + TOT - 1] !== {2'd2, 17'(R2 - 1), 8'(TOT - 1)}) begin errors++; $display("FAIL seq_last got %h required r2 last", got_q[gb + TOT - 1]); end
    vectors++; if (byte_count !== 25'(TOT)) begin errors++; $display("FAIL seq_byte_count got %h required %h", byte_count, TOT); end
    vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL seq_load_err got %b required 0", load_err); end
    vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL seq_done_pulses got %0d required 1", done_cnt - d0); end
    vectors++; if (rom_init !== 1'b0) begin errors++; $display("FAIL seq_rom_init_end got %b required 0", rom_init); end
  endtask

  task automatic test_backpressure();
    int gb, eb, fd, n;
    bit found;
    ack_dly = 10;
    gb = got_q.size(); eb = exp_q.size();
    start_load();
    hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    vectors++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL bp_wait_first got %b required 0", ioctl_wait); end
    hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    vectors++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL bp_wait_second got %b required 1", ioctl_wait); end
    for (int i = 0; i < 18; i++) hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    end_load(found);
    n = exp_q.size() - eb;
    vectors++; if (got_q.size() - gb !== n) begin errors++; $display("FAIL bp_count got %0d required %0d", got_q.size() - gb, n); end
    fd = first_diff(gb, eb, n);
    vectors++; if (fd !== -1) begin errors++; $display("FAIL bp_order write %0d got %h required %h", fd, got_q[gb + fd], exp_q[eb + fd]); end
    vectors++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes required 0", unstable); end
  endtask

  task automatic test_out_of_range();
    int gb, r0;
    bit found;
    ack_dly = 1;
    start_load();
    gb = got_q.size(); r0 = req_rise;
    hps_byte(TOT, 8'h5A);
    repeat (10) begin @(posedge clk_sys); #1; end
    vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b required 1", load_err); end
    vectors++; if (req_rise - r0 !== 0 || got_q.size() !== gb) begin errors++; $display("FAIL oor_no_write got %0d reqs required 0", req_rise - r0); end
    end_load(found);
    vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL oor_err_sticky got %b required 1", load_err); end
    start_load();
    vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got %b required 0", load_err); end
    end_load(found);
  endtask

  task automatic test_overflow();
    int gb, eb, fd;
    int a [3];
    logic [7:0] d [3];
    logic [27:0] m;
    bit found;
    ack_dly = 10;
    gb = got_q.size(); eb = exp_q.size();
    start_load();
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom_range(0, TOT - 1); d[i] = 8'($urandom);
      send_byte(8'd0, a[i], d[i], 1'b0);
      m = model(a[i], d[i]);
      if (i < 2) exp_q.push_back(m[26:0]);
    end
    end_load(found);
    vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b required 1", load_err); end
    fd = first_diff(gb, eb, 2);
    vectors++; if (fd !== -1 || got_q.size() - gb !== 2) begin errors++; $display("FAIL ovf_writes got %0d writes required 2 in order", got_q.size() - gb); end
  endtask

  task automatic test_dip_mod();
    logic [7:0] r;
    int r0;
    r0 = req_rise;
    send_byte(8'd254, 0, 8'hA3, 1'b1);
    vectors++; if (dip_sw !== 8'hA3) begin errors++; $display("FAIL dip_write got %h required a3", dip_sw); end
    send_byte(8'd254, $urandom_range(1, 255), 8'($urandom), 1'b1);
    vectors++; if (dip_sw !== 8'hA3) begin errors++; $display("FAIL dip_other_addr got %h required a3", dip_sw); end
    send_byte(8'd1, $urandom_range(0, 255), 8'h01, 1'b1);
    vectors++; if (mod !== 8'h01) begin errors++; $display("FAIL mod_write got %h required 01", mod); end
    r = 8'($urandom);
    send_byte(8'd1, $urandom_range(0, 255), r, 1'b1);
    vectors++; if (mod !== r) begin errors++; $display("FAIL mod_last got %h required %h", mod, r); end
    vectors++; if (rom_init !== 1'b0 || req_rise - r0 !== 0) begin errors++; $display("FAIL dip_mod_idle rom_init=%b reqs=%0d required 0/0", rom_init, req_rise - r0); end
  endtask

  task automatic test_drain();
    int gb, eb, acks, t;
    ack_dly = 10;
    gb = got_q.size(); eb = exp_q.size();
    start_load();
    hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    ioctl_download = 1'b0;
    acks = 0; t = 0;
    while (acks < 2 && t < 100) begin
      @(negedge clk_sys); t++;
      if (wr_ack) begin
        acks++;
        vectors++; if (rom_init !== 1'b1) begin errors++; $display("FAIL drain_rom_init ack %0d got %b required 1", acks, rom_init); end
      end
    end
    vectors++; if (acks !== 2) begin errors++; $display("FAIL drain_acks got %0d required 2", acks); end
    @(negedge clk_sys);
    vectors++; if ({load_done, rom_init} !== 2'b10) begin errors++; $display("FAIL drain_done done/rom_init got %b required 10", {load_done, rom_init}); end
    @(negedge clk_sys);
    vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL drain_done_once got %b required 0", load_done); end
    @(posedge clk_sys); #1;
    vectors++; if (first_diff(gb, eb, 2) !== -1) begin errors++; $display("FAIL drain_writes got %0d writes required 2 in order", got_q.size() - gb); end
  endtask

  task automatic test_reset_midload();
    logic [64:0] obs;
    int t, r0, gb, eb, fd;
    bit found;
    ack_dly = 10;
    start_load();
    hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    t = 0;
    while (!wr_req && t < 20) begin @(posedge clk_sys); #1; t++; end
    vectors++; if (wr_req !== 1'b1) begin errors++; $display("FAIL rst_setup wr_req got %b required 1", wr_req); end
    #2 reset_n = 1'b0;
    #1;
    obs = {ioctl_wait, wr_req, wr_region, wr_addr, wr_data, rom_init, load_done, load_err, byte_count, dip_sw};
    vectors++; if (obs !== 65'd0 || mod !== 8'hFF) begin errors++; $display("FAIL rst_async got %h mod %h required 0 mod ff", obs, mod); end
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1; reset_n = 1'b1;
    r0 = req_rise;
    repeat (20) begin @(posedge clk_sys); #1; end
    vectors++; if (req_rise - r0 !== 0 || rom_init !== 1'b0) begin errors++; $display("FAIL rst_quiet reqs=%0d rom_init=%b required 0/0", req_rise - r0, rom_init); end
    ack_dly = $urandom_range(0, 3);
    gb = got_q.size(); eb = exp_q.size();
    start_load();
    for (int i = 0; i < 6; i++) hps_byte($urandom_range(0, TOT - 1), 8'($urandom));
    end_load(found);
    fd = first_diff(gb, eb, 6);
    vectors++; if (fd !== -1 || !found) begin errors++; $display("FAIL rst_recover first bad write %0d done=%b required -1/1", fd, found); end
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    test_reset();
    test_seq_load();
    test_backpressure();
    test_out_of_range();
    test_overflow();
    test_dip_mod();
    test_drain();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the HPS ROM download stream (ioctl bus) into the core's ROM/RAM regions: CPU ROM, sound ROM and graphics ROM.
- Decodes each byte's address into a region. Buffers bytes in a 2-entry FIFO. Issues one write at a time to the shared memory write port with a req/ack handshake. Throttles the HPS through ioctl_wait.
- Captures DIP bytes (index 254) and the mod byte (index 1).
- Sits between hps_io and the mylstar/ma216 boards, replacing the ad-hoc rom_init wiring.

Parameters:
- R0_SIZE, 'h10000, CPU ROM bytes; region 0 base is 0.
- R1_SIZE, 'h01000, sound ROM bytes; base = R0_SIZE.
- R2_SIZE, 'h10000, graphics ROM bytes; base = R0_SIZE+R1_SIZE.
- AW, 17, width of the region-relative write address.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to the HPS.
- wr_req  out  1  write request to the memory port.
- wr_region  out  2  target region: 0 CPU, 1 sound, 2 gfx.
- wr_addr  out  AW  region-relative address.
- wr_data  out  8  byte to write.
- wr_ack  in  1  one-cycle write-accepted pulse.
- rom_init  out  1  boards held in load mode.
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  sticky flag: a byte fell beyond R2 end.
- byte_count  out  25  bytes accepted in the current load.
- dip_sw  out  8  DIP byte 0.
- mod  out  8  last mod byte received.

Behaviour:
- Reset values: ioctl_wait=0, wr_req=0, wr_region=0, wr_addr=0, wr_data=0, rom_init=0, load_done=0, load_err=0, byte_count=0, dip_sw=0, mod=8'hFF. FIFO empty; state IDLE.
- States:
  - IDLE -> LOAD when ioctl_download=1 and ioctl_index=0. On entry: byte_count cleared, load_err cleared, rom_init=1.
  - LOAD -> DRAIN when ioctl_download falls.
  - DRAIN -> DONE when the FIFO is empty and no write is outstanding.
  - DONE: load_done=1 for exactly one cycle, rom_init=0, then -> IDLE.
- rom_init=1 in LOAD and DRAIN.
- Byte acceptance, index 0, in LOAD:
  - Each ioctl_wr increments byte_count.
  - addr < R0_SIZE: region 0, offset addr.
  - addr < R0_SIZE+R1_SIZE: region 1, offset addr-R0_SIZE.
  - addr < total: region 2, offset addr-R0_SIZE-R1_SIZE.
  - Otherwise the byte is dropped, load_err set, and nothing is pushed.
  - Offsets are truncated to AW bits.
- FIFO: 2 entries of {region, addr, data}.
  - ioctl_wait=1 when occupancy is 2, or when occupancy is 1 and a push arrives this cycle (registered; asserts the cycle after the second push).
  - A push with the FIFO full is impossible when the HPS honours wait. If it occurs anyway, the byte is dropped and load_err is set.
- Memory handshake:
  - When the FIFO is not empty and no write is outstanding, the head is loaded into wr_* and wr_req=1 the next cycle.
  - wr_* hold stable while wr_req=1.
  - On wr_ack: wr_req=0 and the entry is popped. A new request may issue on the cycle after the ack.
  - Max throughput: one write every 2 cycles.
  - A simultaneous push and pop leaves occupancy unchanged.
- Index 254: bytes with ioctl_addr[24:3]=0 and ioctl_addr[2:0]=0 write dip_sw. They do not enter the FIFO and do not change state.
- Index 1: each ioctl_wr writes mod.
- ioctl_wr with any other index, or in any state other than LOAD for index 0, is ignored.
- A new index-0 download seen in DRAIN is held off: ioctl_wait=1 until DONE, then IDLE -> LOAD.
- reset_n low mid-load: immediate return to the reset values. The outstanding request is abandoned and the FIFO is flushed.

Test Plan:
- Load 'h21000 sequential bytes (data=addr[7:0]) with wr_ack 1 cycle after req:
  - Bytes 0..'hFFFF go to region 0, offsets 0..'hFFFF.
  - Byte 'h10000 goes to region 1, offset 0.
  - Byte 'h11000 goes to region 2, offset 0.
  - Final byte_count='h21000, load_done pulses once, load_err=0.
- Back-pressure: wr_ack delayed 10 cycles, ioctl_wr every cycle while wait=0.
  - ioctl_wait asserts after the 2nd buffered byte.
  - No byte lost or duplicated; write order equals stream order.
- Out-of-range byte at addr 'h21000, data 'h5A:
  - No wr_req for it; load_err=1 until the next load start.
- Index 254 byte 'hA3 at addr 0, then index 1 byte 'h01:
  - dip_sw='hA3, mod='h01, rom_init stays 0.
- ioctl_download falls with 2 entries queued:
  - rom_init stays 1 until the second wr_ack.
  - load_done pulses the following cycle.
- reset_n pulsed low while wr_req=1 in LOAD:
  - All outputs return to reset values asynchronously; no wr_req after release until a new download.
